hazard_ctrl: RTL

Pipeline hazard controller for the 5-stage MIPS core. It sits beside the decoder in ID and owns a two-entry scoreboard of in-flight instructions in EX and MEM. Each cycle it decides whether the ID instruction advances, stalls for a load-use hazard, or is flushed by a taken branch. It also produces registered forwarding selects for the instruction entering EX.

---
 rtl/hazard_ctrl.sv | 165 ++++++++++++++++
 1 files changed

// File: rtl/hazard_ctrl.sv
// Hazard controller beside ID: load-use stall, taken-branch flush and registered EX forwarding selects.
// Define HAZARD_STATS_EN to build the saturating stall/flush statistics counters.
//
// state | meaning
// RUN   | last cycle issued normally (or bubbled an empty ID)
// STALL | last cycle held PC and IF/ID for a load-use hazard
// FLUSH | last cycle squashed the wrong path behind a taken branch
module hazard_ctrl #(
    parameter int AWIDTH = 5,
    parameter int SWIDTH = 16
) (
    input  logic              h_clk,
    input  logic              h_rst,
    input  logic              h_i_ce,
    input  logic [AWIDTH-1:0] h_i_addr_rs,
    input  logic [AWIDTH-1:0] h_i_addr_rt,
    input  logic [AWIDTH-1:0] h_i_addr_rd,
    input  logic              h_i_reg_dst,
    input  logic              h_i_reg_wr,
    input  logic              h_i_alu_src,
    input  logic              h_i_branch,
    input  logic              h_i_memread,
    input  logic              h_i_memwrite,
    input  logic              h_i_br_taken,
    output logic              h_o_pc_we,
    output logic              h_o_ifid_we,
    output logic              h_o_ifid_flush,
    output logic              h_o_idex_bubble,
    output logic [1:0]        h_o_fwd_a,
    output logic [1:0]        h_o_fwd_b,
    output logic [1:0]        h_o_state,
    output logic [SWIDTH-1:0] h_o_stall_cnt,
    output logic [SWIDTH-1:0] h_o_flush_cnt
);

    typedef enum logic [1:0] {
        ST_RUN   = 2'b00,
        ST_STALL = 2'b01,
        ST_FLUSH = 2'b10
    } state_t;

    state_t            state_q, state_d;
    logic              ex_valid_q, ex_wr_q, ex_mrd_q, ex_br_q;
    logic [AWIDTH-1:0] ex_dst_q;
    logic              mem_valid_q, mem_wr_q;
    logic [AWIDTH-1:0] mem_dst_q;
    logic [1:0]        fwd_a_q, fwd_b_q, fwd_a_d, fwd_b_d;

    logic [AWIDTH-1:0] id_dst;
    logic              id_wr, use_rt, ex_load, load_use, br_flush, advance;
    logic              ex_fwd_ok, mem_fwd_ok;

    assign id_dst   = h_i_reg_dst ? h_i_addr_rd : h_i_addr_rt;
    assign id_wr    = h_i_ce & h_i_reg_wr & (id_dst != '0);
    assign use_rt   = h_i_ce & (~h_i_alu_src | h_i_branch | h_i_memwrite);

    assign ex_load  = ex_valid_q & ex_mrd_q & ex_wr_q & (ex_dst_q != '0);
    assign load_use = h_i_ce & ex_load &
                      ((ex_dst_q == h_i_addr_rs) | (use_rt & (ex_dst_q == h_i_addr_rt)));
    assign br_flush = ex_valid_q & ex_br_q & h_i_br_taken;
    assign advance  = h_i_ce & ~br_flush & ~load_use;

    // A load still in EX has no data yet, so only non-load producers forward from EX/MEM.
    assign ex_fwd_ok  = ex_valid_q & ex_wr_q & ~ex_mrd_q & (ex_dst_q != '0);
    assign mem_fwd_ok = mem_valid_q & mem_wr_q & (mem_dst_q != '0);

    function automatic logic [1:0] fwd_sel(
        input logic [AWIDTH-1:0] src,
        input logic              ex_ok,
        input logic [AWIDTH-1:0] ex_dst,
        input logic              mem_ok,
        input logic [AWIDTH-1:0] mem_dst
    );
        if (src == '0)
            return 2'b00;
        else if (ex_ok && (ex_dst == src))
            return 2'b10;
        else if (mem_ok && (mem_dst == src))
            return 2'b01;
        else
            return 2'b00;
    endfunction

    always_comb begin
        h_o_pc_we       = 1'b1;
        h_o_ifid_we     = 1'b1;
        h_o_ifid_flush  = 1'b0;
        h_o_idex_bubble = ~h_i_ce;
        state_d         = ST_RUN;
        if (br_flush) begin
            h_o_ifid_flush  = 1'b1;
            h_o_idex_bubble = 1'b1;
            state_d         = ST_FLUSH;
        end else if (load_use) begin
            h_o_pc_we       = 1'b0;
            h_o_ifid_we     = 1'b0;
            h_o_idex_bubble = 1'b1;
            state_d         = ST_STALL;
        end
    end

    always_comb begin
        fwd_a_d = 2'b00;
        fwd_b_d = 2'b00;
        if (advance) begin
            fwd_a_d = fwd_sel(h_i_addr_rs, ex_fwd_ok, ex_dst_q, mem_fwd_ok, mem_dst_q);
            fwd_b_d = fwd_sel(h_i_addr_rt, ex_fwd_ok, ex_dst_q, mem_fwd_ok, mem_dst_q);
        end
    end

    always_ff @(posedge h_clk or negedge h_rst) begin
        if (!h_rst) begin
            state_q     <= ST_RUN;
            ex_valid_q  <= 1'b0;
            ex_wr_q     <= 1'b0;
            ex_mrd_q    <= 1'b0;
            ex_br_q     <= 1'b0;
            ex_dst_q    <= '0;
            mem_valid_q <= 1'b0;
            mem_wr_q    <= 1'b0;
            mem_dst_q   <= '0;
            fwd_a_q     <= 2'b00;
            fwd_b_q     <= 2'b00;
        end else begin
            state_q     <= state_d;
            mem_valid_q <= ex_valid_q;
            mem_wr_q    <= ex_wr_q;
            mem_dst_q   <= ex_dst_q;
            ex_valid_q  <= advance;
            ex_wr_q     <= advance & id_wr;
            ex_mrd_q    <= advance & h_i_memread;
            ex_br_q     <= advance & h_i_branch;
            ex_dst_q    <= advance ? id_dst : '0;
            fwd_a_q     <= fwd_a_d;
            fwd_b_q     <= fwd_b_d;
        end
    end

    assign h_o_fwd_a = fwd_a_q;
    assign h_o_fwd_b = fwd_b_q;
    assign h_o_state = state_q;

`ifdef HAZARD_STATS_EN
    logic [SWIDTH-1:0] stall_cnt_q, flush_cnt_q;

    always_ff @(posedge h_clk or negedge h_rst) begin
        if (!h_rst) begin
            stall_cnt_q <= '0;
            flush_cnt_q <= '0;
        end else begin
            if (load_use && !br_flush && !(&stall_cnt_q))
                stall_cnt_q <= stall_cnt_q + SWIDTH'(1);
            if (br_flush && !(&flush_cnt_q))
                flush_cnt_q <= flush_cnt_q + SWIDTH'(1);
        end
    end

    assign h_o_stall_cnt = stall_cnt_q;
    assign h_o_flush_cnt = flush_cnt_q;
`else
    assign h_o_stall_cnt = '0;
    assign h_o_flush_cnt = '0;
`endif

endmodule
